axi_rd_arbiter: RTL and testbench

- Two-requester arbiter sharing the single read port of the dram wrapper: the AR channel and in-order R channel behind the AR FIFO, delay model and axi_ram.
- Requester 0 is demand (CPU-side) reads; requester 1 is prefetcher reads.
- Grants AR with demand priority plus a starvation guard, and records the grant order in a source FIFO.
- Routes returning R bursts to the owning requester. The dram returns bursts in AR order, so routing is by order, not by ID.

---
 rtl/axi_rd_arbiter.sv | 167 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter in front of a single in-order read port.
// AR grants demand reads first with a starvation guard; R bursts are routed back by grant order.
module axi_rd_arbiter #(
   parameter int ADDR_WIDTH      = 16,
   parameter int DATA_WIDTH      = 32,
   parameter int ID_WIDTH        = 8,
   parameter int LOG_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4,
   parameter int STARVE_WIDTH    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   // requester 0 (demand)
   input  logic                  s0_ar_valid,
   output logic                  s0_ar_ready,
   input  logic [ADDR_WIDTH-1:0] s0_ar_addr,
   input  logic [7:0]            s0_ar_len,
   input  logic [ID_WIDTH-1:0]   s0_ar_id,
   output logic                  s0_r_valid,
   input  logic                  s0_r_ready,
   output logic [DATA_WIDTH-1:0] s0_r_data,
   output logic [ID_WIDTH-1:0]   s0_r_id,
   output logic [1:0]            s0_r_resp,
   output logic                  s0_r_last,
   // requester 1 (prefetch)
   input  logic                  s1_ar_valid,
   output logic                  s1_ar_ready,
   input  logic [ADDR_WIDTH-1:0] s1_ar_addr,
   input  logic [7:0]            s1_ar_len,
   input  logic [ID_WIDTH-1:0]   s1_ar_id,
   output logic                  s1_r_valid,
   input  logic                  s1_r_ready,
   output logic [DATA_WIDTH-1:0] s1_r_data,
   output logic [ID_WIDTH-1:0]   s1_r_id,
   output logic [1:0]            s1_r_resp,
   output logic                  s1_r_last,
   // downstream
   output logic                  m_ar_valid,
   input  logic                  m_ar_ready,
   output logic [ADDR_WIDTH-1:0] m_ar_addr,
   output logic [7:0]            m_ar_len,
   output logic [ID_WIDTH-1:0]   m_ar_id,
   input  logic                  m_r_valid,
   output logic                  m_r_ready,
   input  logic [DATA_WIDTH-1:0] m_r_data,
   input  logic [ID_WIDTH-1:0]   m_r_id,
   input  logic [1:0]            m_r_resp,
   input  logic                  m_r_last
);

   localparam int DEPTH = 1 << LOG_OUTSTANDING;

   typedef enum logic {IDLE, HOLD} state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [7:0]            len;
      logic [ID_WIDTH-1:0]   id;
   } ar_req_t;

   state_t                   state_q, state_d;
   ar_req_t                  s0_req, s1_req, grant_req, m_ar_q;
   logic [STARVE_WIDTH-1:0]  starve_cnt;
   logic [DEPTH-1:0]         src_fifo;
   logic [LOG_OUTSTANDING-1:0] wr_ptr, rd_ptr;
   logic [LOG_OUTSTANDING:0] count;
   logic full, empty, starved, pick1, push, pop, head;

   assign full    = (count == (LOG_OUTSTANDING+1)'(DEPTH));
   assign empty   = (count == '0);
   assign starved = (starve_cnt == STARVE_WIDTH'(STARVE_LIMIT));

   // Requester 1 wins when alone, or when it has lost STARVE_LIMIT arbitrations in a row.
   assign pick1 = s1_ar_valid & (~s0_ar_valid | starved);

   assign s0_req    = '{addr: s0_ar_addr, len: s0_ar_len, id: s0_ar_id};
   assign s1_req    = '{addr: s1_ar_addr, len: s1_ar_len, id: s1_ar_id};
   assign grant_req = pick1 ? s1_req : s0_req;

   always_comb begin
      state_d     = state_q;
      s0_ar_ready = 1'b0;
      s1_ar_ready = 1'b0;
      m_ar_valid  = 1'b0;
      case (state_q)
         IDLE: begin
            // Full is the registered count: a same-cycle pop does not open a slot.
            if (rst && !full) begin
               s0_ar_ready = s0_ar_valid & ~pick1;
               s1_ar_ready = pick1;
               if (s0_ar_valid || s1_ar_valid) state_d = HOLD;
            end
         end
         HOLD: begin
            m_ar_valid = 1'b1;
            if (m_ar_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign push = s0_ar_ready | s1_ar_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         m_ar_q  <= '0;
      end else begin
         state_q <= state_d;
         if (push) m_ar_q <= grant_req;
      end
   end

   assign m_ar_addr = m_ar_q.addr;
   assign m_ar_len  = m_ar_q.len;
   assign m_ar_id   = m_ar_q.id;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (push) begin
         if (pick1)
            starve_cnt <= '0;
         else if (s1_ar_valid && !(&starve_cnt))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Source FIFO: one bit per outstanding burst naming its owner, in AR order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src_fifo <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            src_fifo[wr_ptr] <= pick1;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head = src_fifo[rd_ptr];

   // R beats with no outstanding burst are stalled rather than dropped.
   assign m_r_ready  = ~empty & (head ? s1_r_ready : s0_r_ready);
   assign s0_r_valid = m_r_valid & ~empty & ~head;
   assign s1_r_valid = m_r_valid & ~empty & head;
   assign pop        = m_r_valid & m_r_ready & m_r_last;

   assign s0_r_data = m_r_data;
   assign s0_r_id   = m_r_id;
   assign s0_r_resp = m_r_resp;
   assign s0_r_last = m_r_last;
   assign s1_r_data = m_r_data;
   assign s1_r_id   = m_r_id;
   assign s1_r_resp = m_r_resp;
   assign s1_r_last = m_r_last;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: arbitration table plus hand sequences for
// reset, fill, R routing order and simultaneous push/pop.
module tb_axi_rd_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        s0_ar_valid, s0_ar_ready, s1_ar_valid, s1_ar_ready;
   logic [15:0] s0_ar_addr, s1_ar_addr, m_ar_addr;
   logic [7:0]  s0_ar_len, s1_ar_len, m_ar_len;
   logic [7:0]  s0_ar_id, s1_ar_id, m_ar_id;
   logic        s0_r_valid, s0_r_ready, s1_r_valid, s1_r_ready;
   logic [31:0] s0_r_data, s1_r_data, m_r_data;
   logic [7:0]  s0_r_id, s1_r_id, m_r_id;
   logic [1:0]  s0_r_resp, s1_r_resp, m_r_resp;
   logic        s0_r_last, s1_r_last, m_r_last;
   logic        m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   axi_rd_arbiter dut (
      .clk(clk), .rst(rst),
      .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready), .s0_ar_addr(s0_ar_addr),
      .s0_ar_len(s0_ar_len), .s0_ar_id(s0_ar_id),
      .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready), .s0_r_data(s0_r_data),
      .s0_r_id(s0_r_id), .s0_r_resp(s0_r_resp), .s0_r_last(s0_r_last),
      .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready), .s1_ar_addr(s1_ar_addr),
      .s1_ar_len(s1_ar_len), .s1_ar_id(s1_ar_id),
      .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready), .s1_r_data(s1_r_data),
      .s1_r_id(s1_r_id), .s1_r_resp(s1_r_resp), .s1_r_last(s1_r_last),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
      .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
      .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
      .m_r_id(m_r_id), .m_r_resp(m_r_resp), .m_r_last(m_r_last)
   );

   typedef struct {
      logic       s0v;
      logic       s1v;
      logic       exp_src;
      logic [2:0] exp_starve;
   } arb_vec_t;

   arb_vec_t tab [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One AR from src, accepted downstream immediately; returns in IDLE.
   task automatic grant(input logic src, input logic [7:0] len, input logic [7:0] id);
      m_ar_ready = 1'b1;
      if (src) begin
         s1_ar_valid = 1'b1; s1_ar_len = len; s1_ar_id = id;
      end else begin
         s0_ar_valid = 1'b1; s0_ar_len = len; s0_ar_id = id;
      end
      #1;
      chk("grant_ready", src ? s1_ar_ready : s0_ar_ready, 1);
      cyc();
      s0_ar_valid = 1'b0;
      s1_ar_valid = 1'b0;
      cyc();
   endtask

   initial begin
      tab[0]  = '{1, 1, 0, 1};
      tab[1]  = '{1, 1, 0, 2};
      tab[2]  = '{1, 1, 0, 3};
      tab[3]  = '{1, 1, 0, 4};
      tab[4]  = '{1, 1, 1, 0};
      tab[5]  = '{1, 1, 0, 1};
      tab[6]  = '{1, 1, 0, 2};
      tab[7]  = '{1, 1, 0, 3};
      tab[8]  = '{1, 1, 0, 4};
      tab[9]  = '{1, 1, 1, 0};
      tab[10] = '{1, 0, 0, 0};
      tab[11] = '{0, 1, 1, 0};
      tab[12] = '{1, 1, 0, 1};

      rst = 1'b0;
      s0_ar_valid = 1'b1; s0_ar_addr = '0; s0_ar_len = '0; s0_ar_id = '0;
      s1_ar_valid = 1'b0; s1_ar_addr = '0; s1_ar_len = '0; s1_ar_id = '0;
      s0_r_ready = 1'b0; s1_r_ready = 1'b0;
      m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_data = '0; m_r_id = '0;
      m_r_resp = '0; m_r_last = 1'b0;
      #2;
      chk("rst_m_ar_valid", m_ar_valid, 0);
      chk("rst_m_ar_addr", m_ar_addr, 0);
      chk("rst_s0_ar_ready", s0_ar_ready, 0);
      chk("rst_count", dut.count, 0);
      s0_ar_valid = 1'b0;
      repeat (2) cyc();
      rst = 1'b1;
      cyc();

      // Reset while holding an AR downstream
      s0_ar_valid = 1'b1; s0_ar_addr = 16'h0100; s0_ar_id = 8'h01; m_ar_ready = 1'b0;
      #1;
      chk("t1_s0_ready", s0_ar_ready, 1);
      cyc();
      s0_ar_valid = 1'b0;
      #1;
      chk("t1_hold_valid", m_ar_valid, 1);
      chk("t1_hold_addr", m_ar_addr, 16'h0100);
      cyc();
      chk("t1_hold_stable", m_ar_valid, 1);
      rst = 1'b0;
      #1;
      chk("t1_rst_valid", m_ar_valid, 0);
      chk("t1_rst_count", dut.count, 0);
      cyc();
      rst = 1'b1;
      cyc();

      // Only s1, len 3
      s1_ar_valid = 1'b1; s1_ar_addr = 16'h0040; s1_ar_len = 8'd3; s1_ar_id = 8'h21;
      m_ar_ready = 1'b1;
      #1;
      chk("t2_s1_ready", s1_ar_ready, 1);
      chk("t2_s0_ready", s0_ar_ready, 0);
      chk("t2_pre_valid", m_ar_valid, 0);
      cyc();
      s1_ar_valid = 1'b0;
      #1;
      chk("t2_ar_valid", m_ar_valid, 1);
      chk("t2_ar_addr", m_ar_addr, 16'h0040);
      chk("t2_ar_len", m_ar_len, 3);
      chk("t2_ar_id", m_ar_id, 8'h21);
      cyc();
      chk("t2_ar_done", m_ar_valid, 0);
      s1_r_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         m_r_valid = 1'b1; m_r_data = 32'hD000_0000 + b; m_r_id = 8'h21; m_r_last = (b == 3);
         #1;
         chk("t2_s1_r_valid", s1_r_valid, 1);
         chk("t2_s0_r_valid", s0_r_valid, 0);
         chk("t2_m_r_ready", m_r_ready, 1);
         chk("t2_s1_r_data", s1_r_data, 32'hD000_0000 + b);
         cyc();
         chk("t2_count", dut.count, (b < 3) ? 1 : 0);
      end
      // Beat with nothing outstanding stalls
      m_r_valid = 1'b1; m_r_last = 1'b1;
      #1;
      chk("empty_m_r_ready", m_r_ready, 0);
      chk("empty_s0_r_valid", s0_r_valid, 0);
      chk("empty_s1_r_valid", s1_r_valid, 0);

      // Arbitration table; R side drains every burst as a single last beat
      s0_ar_id = 8'hA0; s1_ar_id = 8'hB1; s0_r_ready = 1'b1; s1_r_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         s0_ar_valid = tab[i].s0v; s1_ar_valid = tab[i].s1v;
         #1;
         chk("arb_s0_ready", s0_ar_ready, !tab[i].exp_src);
         chk("arb_s1_ready", s1_ar_ready, tab[i].exp_src);
         cyc();
         s0_ar_valid = 1'b0; s1_ar_valid = 1'b0;
         chk("arb_m_ar_id", m_ar_id, tab[i].exp_src ? 8'hB1 : 8'hA0);
         chk("arb_starve", dut.starve_cnt, tab[i].exp_starve);
         cyc();
      end
      m_r_valid = 1'b0; m_r_last = 1'b0;
      cyc();
      chk("arb_count", dut.count, 0);

      // Fill the source FIFO, then free one slot
      for (int k = 0; k < 4; k++) grant(0, 8'd0, 8'h30 + 8'(k));
      s0_ar_valid = 1'b1; s1_ar_valid = 1'b1;
      #1;
      chk("fill_count", dut.count, 4);
      chk("fill_s0_ready", s0_ar_ready, 0);
      chk("fill_s1_ready", s1_ar_ready, 0);
      cyc();
      chk("fill_stall_s0", s0_ar_ready, 0);
      m_r_valid = 1'b1; m_r_last = 1'b1;
      #1;
      chk("fill_pop_ready", m_r_ready, 1);
      chk("fill_prepop_ready", s0_ar_ready, 0);
      cyc();
      m_r_valid = 1'b0;
      chk("fill_after_pop", dut.count, 3);
      chk("fill_regrant", s0_ar_ready, 1);
      cyc();
      s0_ar_valid = 1'b0; s1_ar_valid = 1'b0;
      chk("fill_refull", dut.count, 4);
      chk("fill_regrant_valid", m_ar_valid, 1);
      cyc();
      m_r_valid = 1'b1;
      repeat (4) cyc();
      m_r_valid = 1'b0;
      chk("fill_drained", dut.count, 0);

      // Routing by grant order with a stalled requester 0
      grant(0, 8'd1, 8'h10);
      grant(1, 8'd0, 8'h11);
      s0_r_ready = 1'b0; s1_r_ready = 1'b1;
      m_r_valid = 1'b1; m_r_data = 32'hE1; m_r_last = 1'b0;
      #1;
      chk("ord_stall_s0_valid", s0_r_valid, 1);
      chk("ord_stall_m_ready", m_r_ready, 0);
      chk("ord_stall_s1_valid", s1_r_valid, 0);
      cyc();
      chk("ord_stall_count", dut.count, 2);
      s0_r_ready = 1'b1;
      #1;
      chk("ord_b1_ready", m_r_ready, 1);
      cyc();
      m_r_data = 32'hE2; m_r_last = 1'b1;
      #1;
      chk("ord_b2_s0_valid", s0_r_valid, 1);
      cyc();
      chk("ord_b2_count", dut.count, 1);
      m_r_data = 32'hE3;
      #1;
      chk("ord_b3_s1_valid", s1_r_valid, 1);
      chk("ord_b3_s0_valid", s0_r_valid, 0);
      chk("ord_b3_data", s1_r_data, 32'hE3);
      cyc();
      m_r_valid = 1'b0;
      chk("ord_count", dut.count, 0);

      // Pop and push in the same cycle at count 2
      grant(0, 8'd0, 8'h40);
      grant(1, 8'd0, 8'h41);
      s0_ar_valid = 1'b1; s0_ar_id = 8'h42;
      m_r_valid = 1'b1; m_r_last = 1'b1;
      #1;
      chk("sim_ar_ready", s0_ar_ready, 1);
      chk("sim_s0_r_valid", s0_r_valid, 1);
      chk("sim_m_r_ready", m_r_ready, 1);
      cyc();
      s0_ar_valid = 1'b0;
      chk("sim_count", dut.count, 2);
      chk("sim_head_s1", s1_r_valid, 1);
      chk("sim_head_s0", s0_r_valid, 0);
      cyc();
      cyc();
      m_r_valid = 1'b0;
      chk("sim_drained", dut.count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
